// File: rtl/issue_dispatch_ctrl_if.sv
// Decoder-side and back-end-side signals of the issue/dispatch controller.
`timescale 1ns/1ps
interface issue_dispatch_ctrl_if #(
  parameter int PAYLOAD_W = 64,
  parameter int ROB_BIT   = 5
);
  logic                 dec_valid;
  logic [1:0]           dec_unit;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic                 dec_stall;
  logic                 rob_commit;
  logic                 rs_release;
  logic                 lsb_release;
  logic                 flush;
  logic                 iss_rob_valid;
  logic                 iss_rs_valid;
  logic                 iss_lsb_valid;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [ROB_BIT-1:0]   iss_rob_tag;
  logic [ROB_BIT:0]     rob_free_cnt;

  modport master (
    output dec_valid, dec_unit, dec_payload, rob_commit, rs_release, lsb_release, flush,
    input  dec_stall, iss_rob_valid, iss_rs_valid, iss_lsb_valid, iss_payload,
           iss_rob_tag, rob_free_cnt
  );

  modport slave (
    input  dec_valid, dec_unit, dec_payload, rob_commit, rs_release, lsb_release, flush,
    output dec_stall, iss_rob_valid, iss_rs_valid, iss_lsb_valid, iss_payload,
           iss_rob_tag, rob_free_cnt
  );
endinterface

// File: rtl/issue_dispatch_ctrl.sv
// Single-entry issue stage: holds one decoded instruction, issues it into ROB/RS/LSB
// when credits allow, allocates ROB tags in order and drains on flush.
//
// state    | meaning
// ST_EMPTY | hold register empty, decoder may deliver
// ST_HOLD  | one instruction held, waiting for credits or issuing
// ST_FLUSH | one-cycle drain after a flush; decoder stalled
`timescale 1ns/1ps
module issue_dispatch_ctrl #(
  parameter int PAYLOAD_W = 64,
  parameter int ROB_SIZE  = 32,
  parameter int ROB_BIT   = 5,
  parameter int RS_SIZE   = 8,
  parameter int LSB_SIZE  = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  issue_dispatch_ctrl_if.slave  bus
);
  localparam int RS_W  = $clog2(RS_SIZE + 1);
  localparam int LSB_W = $clog2(LSB_SIZE + 1);
  localparam logic [ROB_BIT:0]   ROB_FULL = (ROB_BIT+1)'(ROB_SIZE);
  localparam logic [ROB_BIT:0]   ROB_ONE  = (ROB_BIT+1)'(1);
  localparam logic [RS_W-1:0]    RS_FULL  = RS_W'(RS_SIZE);
  localparam logic [RS_W-1:0]    RS_ONE   = RS_W'(1);
  localparam logic [LSB_W-1:0]   LSB_FULL = LSB_W'(LSB_SIZE);
  localparam logic [LSB_W-1:0]   LSB_ONE  = LSB_W'(1);
  localparam logic [ROB_BIT-1:0] TAG_ONE  = ROB_BIT'(1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [PAYLOAD_W-1:0] hold_payload;
  logic [1:0]           hold_unit;
  logic [ROB_BIT:0]     rob_cr;
  logic [RS_W-1:0]      rs_cr;
  logic [LSB_W-1:0]     lsb_cr;
  logic [ROB_BIT-1:0]   tail;
  logic                 rob_v_q, rs_v_q, lsb_v_q;
  logic [PAYLOAD_W-1:0] iss_payload_q;
  logic [ROB_BIT-1:0]   iss_tag_q;
  logic                 unit_ok, can_issue, issue, stall, accept, use_rs, use_lsb;

  always_comb begin
    unit_ok   = 1'b1;
    case (hold_unit)
      2'd1:    unit_ok = (rs_cr != '0);
      2'd2:    unit_ok = (lsb_cr != '0);
      default: unit_ok = 1'b1;
    endcase
    can_issue = rdy_in && (state == ST_HOLD) && (rob_cr != '0) && unit_ok;
    issue     = can_issue && !bus.flush;
    use_rs    = issue && (hold_unit == 2'd1);
    use_lsb   = issue && (hold_unit == 2'd2);
    stall     = !rdy_in || (state == ST_FLUSH) || ((state == ST_HOLD) && !can_issue);
    accept    = bus.dec_valid && !stall && !bus.flush;

    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_HOLD;
        ST_HOLD:  if (issue && !accept) state_nxt = ST_EMPTY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_EMPTY;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_payload  <= '0;
      hold_unit     <= 2'd0;
      rob_cr        <= ROB_FULL;
      rs_cr         <= RS_FULL;
      lsb_cr        <= LSB_FULL;
      tail          <= '0;
      rob_v_q       <= 1'b0;
      rs_v_q        <= 1'b0;
      lsb_v_q       <= 1'b0;
      iss_payload_q <= '0;
      iss_tag_q     <= '0;
    end else if (rdy_in) begin
      if (bus.flush) begin
        hold_payload  <= '0;
        hold_unit     <= 2'd0;
        rob_cr        <= ROB_FULL;
        rs_cr         <= RS_FULL;
        lsb_cr        <= LSB_FULL;
        tail          <= '0;
        rob_v_q       <= 1'b0;
        rs_v_q        <= 1'b0;
        lsb_v_q       <= 1'b0;
        iss_payload_q <= '0;
        iss_tag_q     <= '0;
      end else begin
        rob_v_q <= issue;
        rs_v_q  <= use_rs;
        lsb_v_q <= use_lsb;
        if (issue) begin
          iss_payload_q <= hold_payload;
          iss_tag_q     <= tail;
          tail          <= tail + TAG_ONE;
        end
        // a release while already full saturates; issue+release nets to zero
        if (bus.rob_commit && !issue) begin
          if (rob_cr != ROB_FULL) rob_cr <= rob_cr + ROB_ONE;
        end else if (!bus.rob_commit && issue) begin
          rob_cr <= rob_cr - ROB_ONE;
        end
        if (bus.rs_release && !use_rs) begin
          if (rs_cr != RS_FULL) rs_cr <= rs_cr + RS_ONE;
        end else if (!bus.rs_release && use_rs) begin
          rs_cr <= rs_cr - RS_ONE;
        end
        if (bus.lsb_release && !use_lsb) begin
          if (lsb_cr != LSB_FULL) lsb_cr <= lsb_cr + LSB_ONE;
        end else if (!bus.lsb_release && use_lsb) begin
          lsb_cr <= lsb_cr - LSB_ONE;
        end
        if (accept) begin
          hold_payload <= bus.dec_payload;
          hold_unit    <= (bus.dec_unit == 2'd3) ? 2'd0 : bus.dec_unit;
        end
      end
    end
  end

  // valids stay registered while frozen and are only shown once the pipeline runs again
  assign bus.dec_stall     = stall;
  assign bus.iss_rob_valid = rob_v_q & rdy_in;
  assign bus.iss_rs_valid  = rs_v_q & rdy_in;
  assign bus.iss_lsb_valid = lsb_v_q & rdy_in;
  assign bus.iss_payload   = iss_payload_q;
  assign bus.iss_rob_tag   = iss_tag_q;
  assign bus.rob_free_cnt  = rob_cr;
endmodule
